// File: rtl/multi_channel_timed_feedback.sv
`default_nettype none
// ============================================================================
//  Module      : multi_channel_timed_feedback
//  Description : Compares several ADC-derived channels against per-channel
//                hysteresis thresholds and combines the masked flags (OR/AND).
//                A qualified condition fires a timed active pulse followed by
//                a hold-off, with optional one-shot lockout and early release.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_timed_feedback #(
  parameter int channelCount   = 4,
  parameter int inputBitSize   = 16,
  parameter int outputBitSize  = 16,
  parameter bit isInputSigned  = 1'b1,
  parameter int counterBitSize = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [channelCount*inputBitSize-1:0] in,
  input  logic [channelCount*inputBitSize-1:0] thresholdHigh,
  input  logic [channelCount*inputBitSize-1:0] thresholdLow,
  input  logic [channelCount-1:0]              actOnGreater,
  input  logic [channelCount-1:0]              channelMask,
  input  logic                                 combineAnd,
  input  logic                                 oneShot,
  input  logic                                 releaseOnClear,
  input  logic                                 rearm,
  input  logic [counterBitSize-1:0]            cyclesForActivation,
  input  logic [counterBitSize-1:0]            activeMaxCycles,
  input  logic [counterBitSize-1:0]            idleWaitCycles,
  input  logic [outputBitSize-1:0]             valueWhenIdle,
  input  logic [outputBitSize-1:0]             valueWhenActive,
  output logic [outputBitSize-1:0]             out,
  output logic                                 active,
  output logic                                 locked,
  output logic [15:0]                          triggerCount
);

  localparam int c_BUS_W = channelCount * inputBitSize;
  localparam logic [counterBitSize-1:0] c_ONE = {{(counterBitSize-1){1'b0}}, 1'b1};

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ACTIVE  = 3'd1;
  localparam logic [2:0] c_HOLDOFF = 3'd2;
  localparam logic [2:0] c_LOCKED  = 3'd3;

  logic [c_BUS_W-1:0]        r_in;
  logic [c_BUS_W-1:0]        r_th_hi;
  logic [c_BUS_W-1:0]        r_th_lo;
  logic [channelCount-1:0]   r_flag;
  logic [channelCount-1:0]   w_flag_nxt;
  logic [counterBitSize-1:0] r_qual_cnt;
  logic [counterBitSize-1:0] r_cnt;
  logic [counterBitSize-1:0] w_cnt_nxt;
  logic [counterBitSize-1:0] w_pulse_m1;
  logic [counterBitSize-1:0] w_wait_m1;
  logic [2:0]                r_state;
  logic [2:0]                w_state_nxt;
  logic [outputBitSize-1:0]  w_out_nxt;
  logic                      w_any;
  logic                      w_all;
  logic                      w_cond;
  logic                      w_qualified;
  logic                      w_trigger;
  logic                      w_end;

  // Stage 1: capture inputs and thresholds every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in    <= '0;
      r_th_hi <= '0;
      r_th_lo <= '0;
    end else begin
      r_in    <= in;
      r_th_hi <= thresholdHigh;
      r_th_lo <= thresholdLow;
    end
  end

  // Per-channel hysteresis; set wins when the bounds are inverted
  for (genvar gi = 0; gi < channelCount; gi++) begin : g_ch
    logic [inputBitSize-1:0] w_x;
    logic [inputBitSize-1:0] w_hi;
    logic [inputBitSize-1:0] w_lo;
    logic                    w_above;
    logic                    w_below;
    logic                    w_set;
    logic                    w_clr;
    assign w_x  = r_in[gi*inputBitSize +: inputBitSize];
    assign w_hi = r_th_hi[gi*inputBitSize +: inputBitSize];
    assign w_lo = r_th_lo[gi*inputBitSize +: inputBitSize];
    if (isInputSigned) begin : g_signed
      assign w_above = $signed(w_x) > $signed(w_hi);
      assign w_below = $signed(w_x) < $signed(w_lo);
    end else begin : g_unsigned
      assign w_above = w_x > w_hi;
      assign w_below = w_x < w_lo;
    end
    assign w_set = actOnGreater[gi] ? w_above : w_below;
    assign w_clr = actOnGreater[gi] ? w_below : w_above;
    assign w_flag_nxt[gi] = w_set | (r_flag[gi] & ~w_clr);
  end

  // Stage 2: register channel flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_flag <= '0;
    else        r_flag <= w_flag_nxt;
  end

  // An all-zero mask never produces a condition, even in AND mode
  assign w_any  = |(r_flag & channelMask);
  assign w_all  = &(r_flag | ~channelMask);
  assign w_cond = (channelMask != '0) && (combineAnd ? w_all : w_any);

  // Qualification counter: saturating run length of the combined condition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_qual_cnt <= '0;
    else if (!enable || !w_cond)   r_qual_cnt <= '0;
    else if (r_qual_cnt != '1)     r_qual_cnt <= r_qual_cnt + c_ONE;
  end

  assign w_qualified = w_cond && (r_qual_cnt >= cyclesForActivation);
  // A zero pulse length is treated as a single-cycle pulse
  assign w_pulse_m1  = (activeMaxCycles == '0) ? '0 : activeMaxCycles - c_ONE;
  assign w_wait_m1   = idleWaitCycles - c_ONE;

  // State register together with the registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      out          <= '0;
      active       <= 1'b0;
      locked       <= 1'b0;
      triggerCount <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      out     <= w_out_nxt;
      active  <= (w_state_nxt == c_ACTIVE);
      locked  <= (w_state_nxt == c_LOCKED);
      if (w_trigger) triggerCount <= triggerCount + 16'd1;
    end
  end

  // Next-state and counter logic; enable=0 overrides every state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trigger   = 1'b0;
    w_end       = 1'b0;
    if (!enable) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_qualified) w_trigger = 1'b1;
        end
        c_ACTIVE: begin
          if ((releaseOnClear && !w_cond) || (r_cnt == '0)) w_end = 1'b1;
          else                                              w_cnt_nxt = r_cnt - c_ONE;
        end
        c_HOLDOFF: begin
          if (r_cnt != '0)      w_cnt_nxt   = r_cnt - c_ONE;
          else if (oneShot)     w_state_nxt = c_LOCKED;
          else if (w_qualified) w_trigger   = 1'b1;
          else                  w_state_nxt = c_IDLE;
        end
        c_LOCKED: begin
          if (rearm) w_state_nxt = c_IDLE;
        end
        default: w_state_nxt = c_IDLE;
      endcase
      if (w_end) begin
        if (idleWaitCycles != '0) begin
          w_state_nxt = c_HOLDOFF;
          w_cnt_nxt   = w_wait_m1;
        end else if (oneShot) begin
          w_state_nxt = c_LOCKED;
        end else if (w_qualified) begin
          w_trigger = 1'b1;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      if (w_trigger) begin
        w_state_nxt = c_ACTIVE;
        w_cnt_nxt   = w_pulse_m1;
      end
    end
  end

  // Output value follows the state being entered
  always_comb begin
    w_out_nxt = (w_state_nxt == c_ACTIVE) ? valueWhenActive : valueWhenIdle;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_timed_feedback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_channel_timed_feedback
//  Description : Self-checking bench for multi_channel_timed_feedback; a
//                signed and an unsigned instance share all stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_timed_feedback;

  localparam logic [15:0] VI = 16'h1111;
  localparam logic [15:0] VA = 16'hAAAA;

  typedef struct packed {
    logic [15:0] out_s; logic act_s; logic lock_s; logic [15:0] tc_s;
    logic [15:0] out_u; logic act_u; logic lock_u; logic [15:0] tc_u;
  } exp_t;

  typedef struct packed {
    logic [15:0] in0; logic [15:0] out; logic act; logic [15:0] tc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] ch_in [4];
  logic [63:0] in_bus;
  logic [63:0] th_hi;
  logic [63:0] th_lo;
  logic [3:0]  aog;
  logic [3:0]  mask;
  logic        combine_and;
  logic        one_shot;
  logic        roc;
  logic        rearm;
  logic [31:0] c_act;
  logic [31:0] n_act;
  logic [31:0] w_idle;
  logic [15:0] s_out, u_out, s_tc, u_tc;
  logic        s_act, u_act, s_lock, u_lock;

  exp_t  sb[$];
  string sb_name[$];
  vec_t  tbl[17];
  int    n_vec = 0;
  int    n_err = 0;

  assign in_bus = {ch_in[3], ch_in[2], ch_in[1], ch_in[0]};

  always #5 clk = ~clk;

  multi_channel_timed_feedback #(.isInputSigned(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .in(in_bus),
    .thresholdHigh(th_hi), .thresholdLow(th_lo), .actOnGreater(aog),
    .channelMask(mask), .combineAnd(combine_and), .oneShot(one_shot),
    .releaseOnClear(roc), .rearm(rearm), .cyclesForActivation(c_act),
    .activeMaxCycles(n_act), .idleWaitCycles(w_idle),
    .valueWhenIdle(VI), .valueWhenActive(VA),
    .out(s_out), .active(s_act), .locked(s_lock), .triggerCount(s_tc));

  multi_channel_timed_feedback #(.isInputSigned(1'b0)) dut_u (
    .clk(clk), .reset(reset), .enable(enable), .in(in_bus),
    .thresholdHigh(th_hi), .thresholdLow(th_lo), .actOnGreater(aog),
    .channelMask(mask), .combineAnd(combine_and), .oneShot(one_shot),
    .releaseOnClear(roc), .rearm(rearm), .cyclesForActivation(c_act),
    .activeMaxCycles(n_act), .idleWaitCycles(w_idle),
    .valueWhenIdle(VI), .valueWhenActive(VA),
    .out(u_out), .active(u_act), .locked(u_lock), .triggerCount(u_tc));

  // Pop the oldest expectation and compare it against both instances
  task automatic compare_head();
    exp_t  e;
    string nm;
    e  = sb.pop_front();
    nm = sb_name.pop_front();
    n_vec++;
    if (s_out !== e.out_s || s_act !== e.act_s || s_lock !== e.lock_s || s_tc !== e.tc_s ||
        u_out !== e.out_u || u_act !== e.act_u || u_lock !== e.lock_u || u_tc !== e.tc_u) begin
      n_err++;
      $display("FAIL %s: signed got out=%h act=%b lock=%b tc=%h want out=%h act=%b lock=%b tc=%h | unsigned got out=%h act=%b lock=%b tc=%h want out=%h act=%b lock=%b tc=%h",
               nm, s_out, s_act, s_lock, s_tc, e.out_s, e.act_s, e.lock_s, e.tc_s,
               u_out, u_act, u_lock, u_tc, e.out_u, e.act_u, e.lock_u, e.tc_u);
    end
  endtask

  task automatic push_exp(input logic [15:0] os, input logic a_s, input logic ls, input logic [15:0] ts,
                          input logic [15:0] ou, input logic a_u, input logic lu, input logic [15:0] tu,
                          input string nm);
    exp_t e;
    e = '{os, a_s, ls, ts, ou, a_u, lu, tu};
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // One clock: queue expectation, advance an edge, sample 1 time unit later
  task automatic step2(input logic [15:0] os, input logic a_s, input logic ls, input logic [15:0] ts,
                       input logic [15:0] ou, input logic a_u, input logic lu, input logic [15:0] tu,
                       input string nm);
    push_exp(os, a_s, ls, ts, ou, a_u, lu, tu, nm);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic step(input logic [15:0] o, input logic a, input logic l, input logic [15:0] t,
                      input string nm);
    step2(o, a, l, t, o, a, l, t, nm);
  endtask

  // Pulse reset between phases, away from the clock edge
  task automatic do_reset();
    #2 reset = 1'b0;
    #4 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase A table: ch0 steps 0->200, C=3, N=5, W=4
    tbl[0]  = '{16'd0,   VI, 1'b0, 16'd0};
    tbl[1]  = '{16'd0,   VI, 1'b0, 16'd0};
    tbl[2]  = '{16'd200, VI, 1'b0, 16'd0};
    tbl[3]  = '{16'd200, VI, 1'b0, 16'd0};
    tbl[4]  = '{16'd200, VI, 1'b0, 16'd0};
    tbl[5]  = '{16'd200, VI, 1'b0, 16'd0};
    tbl[6]  = '{16'd200, VI, 1'b0, 16'd0};
    tbl[7]  = '{16'd200, VA, 1'b1, 16'd1};
    tbl[8]  = '{16'd200, VA, 1'b1, 16'd1};
    tbl[9]  = '{16'd200, VA, 1'b1, 16'd1};
    tbl[10] = '{16'd200, VA, 1'b1, 16'd1};
    tbl[11] = '{16'd200, VA, 1'b1, 16'd1};
    tbl[12] = '{16'd200, VI, 1'b0, 16'd1};
    tbl[13] = '{16'd200, VI, 1'b0, 16'd1};
    tbl[14] = '{16'd200, VI, 1'b0, 16'd1};
    tbl[15] = '{16'd200, VI, 1'b0, 16'd1};
    tbl[16] = '{16'd200, VA, 1'b1, 16'd2};

    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) ch_in[i] = 16'd0;
    th_hi = {4{16'd100}}; th_lo = {4{16'd50}};
    aog = 4'b1111; mask = 4'b0001; combine_and = 1'b0;
    one_shot = 1'b0; roc = 1'b0; rearm = 1'b0;
    c_act = 32'd3; n_act = 32'd5; w_idle = 32'd4;
    #1 reset = 1'b0;
    #2;
    push_exp(16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, "reset_state");
    compare_head();
    #9 reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ch_in[0] = tbl[i].in0;
      step(tbl[i].out, tbl[i].act, 1'b0, tbl[i].tc, $sformatf("timing_row%0d", i));
    end

    // Asynchronous reset in the middle of an active pulse
    #3 reset = 1'b0;
    #1;
    push_exp(16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, "async_reset_mid_active");
    compare_head();
    // Phase B: hysteresis observed through early release
    c_act = 32'd0; n_act = 32'd20; w_idle = 32'd0; roc = 1'b1; ch_in[0] = 16'd0;
    #2 reset = 1'b1;
    step(VI, 1'b0, 1'b0, 16'd0, "post_reset_idle");
    ch_in[0] = 16'd200;
    step(VI, 1'b0, 1'b0, 16'd0, "hyst_k");
    step(VI, 1'b0, 1'b0, 16'd0, "hyst_k1");
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_trigger");
    ch_in[0] = 16'd75;
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_between0");
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_between1");
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_between2");
    ch_in[0] = 16'd40;
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_low_m");
    step(VA, 1'b1, 1'b0, 16'd1, "hyst_low_m1");
    step(VI, 1'b0, 1'b0, 16'd1, "hyst_release");
    step(VI, 1'b0, 1'b0, 16'd1, "hyst_idle");

    // Phase C: 16'hFFFF is -1 signed (no trigger) but large unsigned
    do_reset();
    ch_in[0] = 16'hFFFF;
    step(VI, 1'b0, 1'b0, 16'd0, "ffff_k");
    step(VI, 1'b0, 1'b0, 16'd0, "ffff_k1");
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "ffff_trigger");
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "ffff_hold");
    ch_in[0] = 16'd75;
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "u_between0");
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "u_between1");
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "u_between2");
    ch_in[0] = 16'd40;
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "u_low_m");
    step2(VI, 1'b0, 1'b0, 16'd0, VA, 1'b1, 1'b0, 16'd1, "u_low_m1");
    step2(VI, 1'b0, 1'b0, 16'd0, VI, 1'b0, 1'b0, 16'd1, "u_release");

    // Phase D: combine modes with mask 0101, only ch0 of the unmasked over
    do_reset();
    n_act = 32'd3; roc = 1'b0; mask = 4'b0101; combine_and = 1'b0;
    ch_in[0] = 16'd200; ch_in[1] = 16'd200; ch_in[2] = 16'd0; ch_in[3] = 16'd200;
    step(VI, 1'b0, 1'b0, 16'd0, "or_e0");
    step(VI, 1'b0, 1'b0, 16'd0, "or_e1");
    step(VA, 1'b1, 1'b0, 16'd1, "or_trigger");
    do_reset();
    combine_and = 1'b1;
    for (int i = 0; i < 4; i++) step(VI, 1'b0, 1'b0, 16'd0, $sformatf("and_blocked%0d", i));
    ch_in[2] = 16'd200;
    step(VI, 1'b0, 1'b0, 16'd0, "and_e0");
    step(VI, 1'b0, 1'b0, 16'd0, "and_e1");
    step(VA, 1'b1, 1'b0, 16'd1, "and_trigger");
    do_reset();
    mask = 4'b0000; combine_and = 1'b0;
    for (int i = 0; i < 4; i++) step(VI, 1'b0, 1'b0, 16'd0, $sformatf("mask0_or%0d", i));
    combine_and = 1'b1;
    for (int i = 0; i < 3; i++) step(VI, 1'b0, 1'b0, 16'd0, $sformatf("mask0_and%0d", i));

    // Phase E: one-shot with early release, lockout and rearm
    do_reset();
    mask = 4'b0001; combine_and = 1'b0; one_shot = 1'b1; roc = 1'b1;
    n_act = 32'd10; w_idle = 32'd3; ch_in[0] = 16'd200;
    step(VI, 1'b0, 1'b0, 16'd0, "os_e0");
    step(VI, 1'b0, 1'b0, 16'd0, "os_e1");
    ch_in[0] = 16'd0;
    step(VA, 1'b1, 1'b0, 16'd1, "os_trigger");
    step(VA, 1'b1, 1'b0, 16'd1, "os_active2");
    step(VI, 1'b0, 1'b0, 16'd1, "os_early_release");
    ch_in[0] = 16'd200;
    step(VI, 1'b0, 1'b0, 16'd1, "os_holdoff1");
    step(VI, 1'b0, 1'b0, 16'd1, "os_holdoff2");
    step(VI, 1'b0, 1'b1, 16'd1, "os_locked");
    for (int i = 0; i < 3; i++) step(VI, 1'b0, 1'b1, 16'd1, $sformatf("os_stay_locked%0d", i));
    rearm = 1'b1;
    step(VI, 1'b0, 1'b0, 16'd1, "os_rearm");
    rearm = 1'b0;
    step(VA, 1'b1, 1'b0, 16'd2, "os_retrigger");
    rearm = 1'b1;
    step(VA, 1'b1, 1'b0, 16'd2, "rearm_ignored_active");
    rearm = 1'b0;

    // Phase F: enable dropped in hold-off, then N=0 acts as N=1
    do_reset();
    one_shot = 1'b0; roc = 1'b0; c_act = 32'd2; n_act = 32'd2; w_idle = 32'd5;
    ch_in[0] = 16'd200;
    for (int i = 0; i < 4; i++) step(VI, 1'b0, 1'b0, 16'd0, $sformatf("en_qual%0d", i));
    step(VA, 1'b1, 1'b0, 16'd1, "en_trigger");
    step(VA, 1'b1, 1'b0, 16'd1, "en_active2");
    step(VI, 1'b0, 1'b0, 16'd1, "en_holdoff");
    enable = 1'b0;
    step(VI, 1'b0, 1'b0, 16'd1, "en_forced_idle");
    enable = 1'b1; n_act = 32'd0;
    step(VI, 1'b0, 1'b0, 16'd1, "en_requal0");
    step(VI, 1'b0, 1'b0, 16'd1, "en_requal1");
    step(VA, 1'b1, 1'b0, 16'd2, "n0_trigger");
    for (int i = 0; i < 5; i++) step(VI, 1'b0, 1'b0, 16'd2, $sformatf("n0_holdoff%0d", i));
    step(VA, 1'b1, 1'b0, 16'd3, "n0_retrigger");
    step(VI, 1'b0, 1'b0, 16'd3, "n0_single_cycle");

    // Phase G: N=1, W=0 retriggers every cycle; walk triggerCount through wrap
    do_reset();
    c_act = 32'd0; n_act = 32'd1; w_idle = 32'd0;
    step(VI, 1'b0, 1'b0, 16'd0, "wrap_e0");
    step(VI, 1'b0, 1'b0, 16'd0, "wrap_e1");
    step(VA, 1'b1, 1'b0, 16'd1, "wrap_first");
    repeat (65532) @(posedge clk);
    #1;
    step(VA, 1'b1, 1'b0, 16'hFFFE, "wrap_fffe");
    step(VA, 1'b1, 1'b0, 16'hFFFF, "wrap_ffff");
    step(VA, 1'b1, 1'b0, 16'h0000, "wrap_zero");
    step(VA, 1'b1, 1'b0, 16'h0001, "wrap_one");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
